// File: rtl/cntdiv_pkg.sv
// Shared types for the programmable clock divider: channel FSM states,
// the per-channel settings record and the clamp applied to incoming configs.
package cntdiv_pkg;

    // Settings fields are sized for the widest supported WIDTH; narrower
    // channels zero-extend into them and the unused upper bits stay constant.
    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chan_state_t;

    typedef struct packed {
        logic [CFG_W-1:0] div;
        logic [CFG_W-1:0] high;
        logic             oneshot;
    } chan_cfg_t;

    // Keeps div >= 2 and high <= div-1 so div-high can never underflow.
    function automatic chan_cfg_t clamp_cfg(input chan_cfg_t req);
        chan_cfg_t res;
        res = req;
        if (req.div < CFG_W'(2)) begin
            res.div = CFG_W'(2);
        end
        if (req.high > res.div - CFG_W'(1)) begin
            res.high = res.div - CFG_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/cntdiv_chan.sv
// One divider channel: IDLE/RUN/DONE state machine, period counter,
// shadow settings with pending flag, and registered clkdiv/tick/busy.
module cntdiv_chan
    import cntdiv_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
    input  logic [WIDTH-1:0] cfg_high,
    input  logic             cfg_oneshot,
    output logic             pending,
    output logic             clkdiv,
    output logic             tick,
    output logic             busy
);

    localparam chan_cfg_t RESET_CFG = '{
        div:     CFG_W'(DEFAULT_DIV),
        high:    CFG_W'(DEFAULT_DIV / 2),
        oneshot: 1'b0
    };

    chan_state_t      r_state;
    logic [WIDTH-1:0] r_cnt;
    chan_cfg_t        r_act;
    chan_cfg_t        r_shadow;
    logic             r_pending;
    logic             r_clkdiv;
    logic             r_tick;
    logic             r_busy;

    logic [CFG_W-1:0] w_cnt_ext;
    logic             w_run;
    logic             w_last;
    logic             w_in_high;
    logic             w_apply;
    chan_cfg_t        w_req;

    assign w_cnt_ext = CFG_W'(r_cnt);
    assign w_run     = (r_state == RUN);
    assign w_last    = w_run && (w_cnt_ext == r_act.div - CFG_W'(1));
    assign w_in_high = (w_cnt_ext >= r_act.div - r_act.high);
    // Settings only change at a period boundary or while not running.
    assign w_apply   = r_pending && (!w_run || w_last);
    assign w_req     = '{div: CFG_W'(cfg_div), high: CFG_W'(cfg_high), oneshot: cfg_oneshot};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_act     <= RESET_CFG;
            // NOTE: the shadow is reset too, so a reset discards any queued config.
            r_shadow  <= RESET_CFG;
            r_pending <= 1'b0;
            r_clkdiv  <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_clkdiv <= w_run && w_in_high;
            r_tick   <= w_last;

            if (cfg_we) begin
                r_shadow  <= clamp_cfg(w_req);
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_act     <= r_shadow;
                r_pending <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_busy <= en;
                    if (en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end else if (w_last) begin
                        r_cnt <= '0;
                        if (r_act.oneshot) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_busy <= 1'b1;
                        end
                    end else begin
                        r_cnt  <= r_cnt + WIDTH'(1);
                        r_busy <= 1'b1;
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                    if (!en) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign pending = r_pending;
    assign clkdiv  = r_clkdiv;
    assign tick    = r_tick;
    assign busy    = r_busy;

endmodule

// File: rtl/cntdiv_prog.sv
// Multi-channel programmable clock divider: decodes the config port onto
// NCH independent cntdiv_chan instances and drives the shared cfg_ready.
module cntdiv_prog
    import cntdiv_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NCH-1:0]                       en,
    input  logic                                 cfg_valid,
    output logic                                 cfg_ready,
    input  logic [$clog2(NCH > 1 ? NCH : 2)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]                     cfg_div,
    input  logic [WIDTH-1:0]                     cfg_high,
    input  logic                                 cfg_oneshot,
    output logic [NCH-1:0]                       clkdiv,
    output logic [NCH-1:0]                       tick,
    output logic [NCH-1:0]                       busy
);

    localparam int CH_W    = $clog2(NCH > 1 ? NCH : 2);
    localparam int CH_SPAN = 1 << CH_W;

    logic [NCH-1:0]     w_pending;
    logic [CH_SPAN-1:0] w_pend_span;
    logic               w_accept;

    // Unused channel codes read as never-pending, so they are accepted and dropped.
    always_comb begin
        w_pend_span             = '0;
        w_pend_span[NCH-1:0]    = w_pending;
    end

    // NOTE: cfg_ready is combinational on cfg_ch; no register sits on this path.
    assign cfg_ready = !rst && !w_pend_span[cfg_ch];
    assign w_accept  = cfg_valid && cfg_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        cntdiv_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .en          (en[g]),
            .cfg_we      (w_accept && (cfg_ch == CH_W'(g))),
            .cfg_div     (cfg_div),
            .cfg_high    (cfg_high),
            .cfg_oneshot (cfg_oneshot),
            .pending     (w_pending[g]),
            .clkdiv      (clkdiv[g]),
            .tick        (tick[g]),
            .busy        (busy[g])
        );
    end

endmodule

// File: tb/tb_cntdiv_prog.sv
// Self-checking bench for cntdiv_prog: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_cntdiv_prog;

    localparam int NCH     = 4;
    localparam int WIDTH   = 16;
    localparam int DEF_DIV = 10;
    localparam int CH_W    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [WIDTH-1:0] cfg_div;
    logic [WIDTH-1:0] cfg_high;
    logic             cfg_oneshot;
    logic [NCH-1:0]   clkdiv;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   busy;

    int n_checks = 0;
    int n_errors = 0;

    cntdiv_prog #(
        .NCH         (NCH),
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
        .cfg_oneshot (cfg_oneshot),
        .clkdiv      (clkdiv),
        .tick        (tick),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: each channel is "stopped", "running at position pos
    // of a div-long period" or "finished"; clkdiv is high during the final
    // `high` positions of a period and tick marks the final position.
    int             m_mode [NCH];  // 0 stopped, 1 running, 2 finished
    int             m_pos  [NCH];
    int             m_div  [NCH];
    int             m_high [NCH];
    bit             m_one  [NCH];
    int             m_sdiv [NCH];
    int             m_shigh[NCH];
    bit             m_sone [NCH];
    bit             m_pend [NCH];
    logic [NCH-1:0] e_clk;
    logic [NCH-1:0] e_tick;
    logic [NCH-1:0] e_busy;
    bit             t_running, t_final, t_take, t_apply;
    int             t_div, t_high;

    always @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                m_mode[c] = 0;  m_pos[c] = 0;
                m_div[c]  = DEF_DIV;  m_high[c]  = DEF_DIV / 2;  m_one[c]  = 0;
                m_sdiv[c] = DEF_DIV;  m_shigh[c] = DEF_DIV / 2;  m_sone[c] = 0;
                m_pend[c] = 0;
            end
            e_clk = '0;  e_tick = '0;  e_busy = '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                t_running = (m_mode[c] == 1);
                t_final   = t_running && (m_pos[c] == m_div[c] - 1);
                t_take    = cfg_valid && !m_pend[c] && (int'(cfg_ch) == c);
                t_apply   = m_pend[c] && (!t_running || t_final);
                e_tick[c] = t_final;
                e_clk[c]  = t_running && (m_pos[c] >= m_div[c] - m_high[c]);

                if (m_mode[c] == 0) begin
                    if (en[c]) begin m_mode[c] = 1; m_pos[c] = 0; end
                end else if (m_mode[c] == 1) begin
                    if (!en[c]) begin
                        m_mode[c] = 0; m_pos[c] = 0;
                    end else if (t_final) begin
                        m_pos[c] = 0;
                        if (m_one[c]) m_mode[c] = 2;
                    end else begin
                        m_pos[c] = m_pos[c] + 1;
                    end
                end else begin
                    if (!en[c]) m_mode[c] = 0;
                end
                e_busy[c] = (m_mode[c] == 1);

                if (t_take) begin
                    t_div  = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
                    t_high = (int'(cfg_high) > t_div - 1) ? t_div - 1 : int'(cfg_high);
                    m_sdiv[c] = t_div;  m_shigh[c] = t_high;  m_sone[c] = cfg_oneshot;
                    m_pend[c] = 1;
                end else if (t_apply) begin
                    m_div[c] = m_sdiv[c];  m_high[c] = m_shigh[c];  m_one[c] = m_sone[c];
                    m_pend[c] = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("model_clkdiv", 32'(clkdiv), 32'(e_clk));
        check("model_tick",   32'(tick),   32'(e_tick));
        check("model_busy",   32'(busy),   32'(e_busy));
        check("model_cfg_ready", 32'(cfg_ready), 32'(!rst && !m_pend[cfg_ch]));
    end

    // Default settings on ch0 from the enable edge: low 5, high 5, tick at 10, 20.
    task automatic run_default_ch0(input string tag);
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            check({tag, "_clkdiv0"}, 32'(clkdiv[0]), 32'(j >= 1 && (j - 1) % 10 >= 5));
            check({tag, "_tick0"},   32'(tick[0]),   32'(j >= 1 && j % 10 == 0));
            check({tag, "_busy0"},   32'(busy[0]),   32'd1);
        end
    endtask

    task automatic send_cfg(input int ch, input int dv, input int hi, input bit one);
        cfg_ch = CH_W'(ch);  cfg_div = WIDTH'(dv);  cfg_high = WIDTH'(hi);
        cfg_oneshot = one;   cfg_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n_tick, n_high, n_busy;
        bit  seen, got;

        rst = 1'b1;  en = '0;  cfg_valid = 1'b0;  cfg_ch = '0;
        cfg_div = '0;  cfg_high = '0;  cfg_oneshot = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_clkdiv", 32'(clkdiv), 32'd0);
        check("reset_tick",   32'(tick),   32'd0);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_ready",  32'(cfg_ready), 32'd0);
        rst = 1'b0;
        en[0] = 1'b1;
        run_default_ch0("dflt");

        // ch1: div=4 high=1 accepted mid-period; current 10-cycle period completes
        en[1] = 1'b1;
        for (int j = 0; j <= 20; j++) begin
            @(negedge clk);
            check("ch1_clkdiv", 32'(clkdiv[1]),
                  32'((j >= 6 && j <= 10) || j == 14 || j == 18));
            check("ch1_tick", 32'(tick[1]), 32'(j == 10 || j == 14 || j == 18));
            if (j == 2) begin
                send_cfg(1, 4, 1, 1'b0);
                #1 check("ch1_ready_before", 32'(cfg_ready), 32'd1);
            end
            if (j == 3) begin
                check("ch1_ready_pending", 32'(cfg_ready), 32'd0);
                cfg_valid = 1'b0;
            end
        end

        // ch2: one-shot div=3 high=1
        send_cfg(2, 3, 1, 1'b1);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        en[2] = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            check("os_busy",   32'(busy[2]),   32'(j <= 2));
            check("os_tick",   32'(tick[2]),   32'(j == 3));
            check("os_clkdiv", 32'(clkdiv[2]), 32'(j == 3));
        end
        en[2] = 1'b0;
        @(negedge clk);
        check("os_idle_busy", 32'(busy[2]), 32'd0);
        en[2] = 1'b1;
        n_tick = 0;  n_high = 0;  n_busy = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            n_tick += int'(tick[2]);  n_high += int'(clkdiv[2]);  n_busy += int'(busy[2]);
        end
        check("os_rerun_ticks", n_tick, 1);
        check("os_rerun_highs", n_high, 1);
        check("os_rerun_busy",  n_busy, 3);

        // ch3 clamping: div=1 high=7 becomes div 2 high 1
        send_cfg(3, 1, 7, 1'b0);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        en[3] = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            check("clamp_clkdiv", 32'(clkdiv[3]), 32'(j >= 2 && j % 2 == 0));
            check("clamp_tick",   32'(tick[3]),   32'(j >= 2 && j % 2 == 0));
            check("clamp_busy",   32'(busy[3]),   32'd1);
        end
        // div=6 high=0: constant-low clkdiv, tick every 6 cycles
        send_cfg(3, 6, 0, 1'b0);
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_tick = 0;  n_high = 0;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            n_tick += int'(tick[3]);  n_high += int'(clkdiv[3]);
        end
        check("high0_ticks", n_tick, 4);
        check("high0_highs", n_high, 0);

        // Two configs to running ch0: second waits for the wrap edge
        send_cfg(0, 8, 3, 1'b0);
        #1 check("cfgA_ready", 32'(cfg_ready), 32'd1);
        @(negedge clk);
        seen = 0;  got = 0;
        for (int n = 1; n <= 25 && !got; n++) begin
            @(negedge clk);
            if (tick[0]) seen = 1;
            cfg_valid = 1'b0;  cfg_ch = 2'd1;
            #1 check("ready_other_ch", 32'(cfg_ready), 32'd1);
            send_cfg(0, 5, 2, 1'b0);
            #1 check("ready_ch0_window", 32'(cfg_ready), 32'(seen));
            if (seen) got = 1;
        end
        if (!got) check("ch0_wrap_timeout", 32'(got), 32'd1);

        // Reset with the second config pending: defaults come back, config is lost
        @(negedge clk);
        cfg_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_clkdiv", 32'(clkdiv), 32'd0);
        check("midrst_tick",   32'(tick),   32'd0);
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_ready",  32'(cfg_ready), 32'd0);
        rst = 1'b0;
        run_default_ch0("after_rst");

        // Randomized traffic, checked every cycle against the model
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 199) == 0);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
            end
            cfg_valid   = ($urandom_range(0, 3) == 0);
            cfg_ch      = CH_W'($urandom_range(0, NCH - 1));
            cfg_div     = WIDTH'($urandom_range(0, 12));
            cfg_high    = WIDTH'($urandom_range(0, 14));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cntdiv_prog.md
# cntdiv_prog

Runtime-programmable, multi-channel clock divider and tick generator for the traffic-light controller. Each of `NCH` channels produces a registered divided clock and a one-cycle period tick, with its own divisor, high time and continuous or one-shot mode. New settings are loaded through a valid/ready port and take effect only at a period boundary, so the outputs never glitch. With default settings each channel matches the fixed divider it replaces: period `DEFAULT_DIV`, high for the upper half of the count.

## Interface
- `NCH`, 4, number of independent channels (≥1)
- `WIDTH`, 16, counter, divisor and high-time width
- `DEFAULT_DIV`, 10, divisor loaded at reset; reset high time is `DEFAULT_DIV/2`
- `clk`  in  1  single clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  NCH  per-channel run enable
- `cfg_valid`  in  1  config request
- `cfg_ready`  out  1  config accepted when `cfg_valid && cfg_ready`
- `cfg_ch`  in  max(1,$clog2(NCH))  target channel; values ≥ NCH are accepted and dropped
- `cfg_div`  in  WIDTH  requested divisor (period in cycles)
- `cfg_high`  in  WIDTH  requested high cycles per period
- `cfg_oneshot`  in  1  1 = one-shot, 0 = continuous
- `clkdiv`  out  NCH  registered divided clock
- `tick`  out  NCH  one-cycle pulse, registered, at the last count of each period
- `busy`  out  NCH  channel is in RUN

## Operation
- Per-channel state: IDLE, RUN, DONE.
  - IDLE → RUN when `en`=1; `cnt` is set to 0.
  - RUN, continuous mode: `cnt` counts 0..div−1 and wraps.
  - RUN, one-shot mode: moves to DONE at the wrap edge.
  - RUN → IDLE whenever `en`=0; `cnt` is set to 0.
  - DONE → IDLE when `en`=0.
- Output registers, computed from pre-edge values:
  - `clkdiv` ← RUN && `cnt` ≥ div−high.
  - `tick` ← RUN && `cnt` == div−1.
  - `busy` ← next state == RUN.
- Clamping is applied when a config is accepted:
  - div < 2 becomes 2.
  - high > div−1 becomes div−1.
  - high = 0 is legal and gives a constant-low `clkdiv`; `tick` still pulses.
- Each channel has a shadow register (div, high, mode) and a `pending` flag.
  - `cfg_ready` = !rst && !pending[cfg_ch]. This is combinational on `cfg_ch`.
  - An accepted config writes the shadow and sets `pending`.
  - The shadow is copied to the active settings, and `pending` cleared, at the first later edge where the channel is in IDLE or DONE, or where it is in RUN with `cnt` == div−1.
  - A config is never applied at its own accept edge.
- Arithmetic: `cnt` is unsigned WIDTH bits. `div`−`high` is computed unsigned, with no underflow thanks to clamping. `cnt` never exceeds div−1.

## Timing
- Reset values on the edge where `rst`=1:
  - `cnt`=0, state IDLE, `pending`=0.
  - Active settings = (DEFAULT_DIV, DEFAULT_DIV/2, continuous).
  - `clkdiv`=0, `tick`=0, `busy`=0.
  - `cfg_ready`=0 while `rst` is high.
- Outputs lag `cnt` by one cycle.
  - First `clkdiv` rise comes div−high+1 cycles after the IDLE→RUN edge.
  - Steady-state period is exactly div cycles, with high for `high` cycles.
- `tick` occurs in the same cycle as the last high cycle of `clkdiv` (when high ≥ 1).
- Dropping `en` forces `clkdiv`/`tick`/`busy` to 0 one edge later.
- Reset mid-operation discards the shadow and any pending config. No partial period is completed.
- Configs to different channels may be accepted on consecutive cycles, one per cycle.

## Structure
- Package `cntdiv_pkg` holds:
  - enum `chan_state_t` (IDLE, RUN, DONE);
  - struct `chan_cfg_t` (div, high, oneshot);
  - clamp function `clamp_cfg`.
- Sub-module `cntdiv_chan`: one channel, covering the FSM, counter, shadow/pending and output registers. It is instantiated NCH times by generate.
- The top level holds the `cfg_ch` decode and the `cfg_ready` mux only.

## Test plan
- Reset, then `en[0]`=1 with defaults:
  - `clkdiv[0]` low 5 cycles, then high 5 cycles, repeating with period 10;
  - `tick[0]` every 10 cycles, first one 10 cycles after the enable edge.
- ch1 running at default, accept div=4 high=1 mid-period:
  - the current 10-cycle period completes;
  - following periods are 4 cycles, with `clkdiv[1]` high for 1 cycle.
- ch2 one-shot div=3 high=1 with `en[2]` held high:
  - `busy[2]` is high 3 cycles;
  - exactly one `tick` and one high cycle;
  - then DONE with all outputs 0;
  - `en` toggled low then high → one more period.
- Clamping:
  - div=1 high=7 → effective div 2 high 1, so `clkdiv` toggles every cycle;
  - div=6 high=0 → `clkdiv` stays 0 and `tick` pulses every 6 cycles.
- Two configs to ch0 while it is RUN:
  - `cfg_ready` is 0 for ch0 after the first accept until the wrap edge, then 1;
  - during that window `cfg_ready` is 1 when `cfg_ch`=1.
- `rst` asserted mid-period with a config pending:
  - next cycle all outputs 0 and defaults restored;
  - the pending config is never applied.
